// File: rtl/zmc2_dot_shifter.sv
// zmc2_dot_shifter
//
// Sprite-pixel serializer for the video path (ZMC2 dot stage). A 32-bit
// sprite graphics word holds four bitplane bytes describing eight pixels.
// The word is loaded into a shift register, and each clock presents one
// pair of 4-bit colour indices. Horizontal flip selects the shift direction
// and the bit positions the pair is read from.
//
// Ports:
//   CLK_12M  in   1   pixel clock, all state changes on the rising edge
//   RESET    in   1   synchronous active-high reset, clears the register
//   EVEN     in   1   swaps the A/B output pair when 1
//   LOAD     in   1   loads CR into the shift register at this edge
//   H        in   1   horizontal flip: 0 = shift right, 1 = shift left
//   CR       in  32   graphics word, one bitplane per byte
//   GAD      out  4   pixel A colour index
//   GBD      out  4   pixel B colour index
//   DOTA     out  1   pixel A is opaque (GAD non-zero)
//   DOTB     out  1   pixel B is opaque (GBD non-zero)

module zmc2_dot_shifter (
  input  logic        CLK_12M,
  input  logic        RESET,
  input  logic        EVEN,
  input  logic        LOAD,
  input  logic        H,
  input  logic [31:0] CR,
  output logic [3:0]  GAD,
  output logic [3:0]  GBD,
  output logic        DOTA,
  output logic        DOTB
);

  logic [31:0] sr;
  logic [3:0]  raw_a;
  logic [3:0]  raw_b;

  // Shift register. Each bitplane byte shifts on its own with zero fill, so
  // after four shifts without a reload the register is empty. An empty
  // register makes the outputs transparent.
  always_ff @(posedge CLK_12M) begin
    if (RESET) begin
      sr <= 32'h0000_0000;
    end else if (LOAD) begin
      sr <= CR;
    end else if (H) begin
      sr <= {sr[29:24], 2'b00, sr[21:16], 2'b00,
             sr[13:8],  2'b00, sr[5:0],   2'b00};
    end else begin
      sr <= {2'b00, sr[31:26], 2'b00, sr[23:18],
             2'b00, sr[15:10], 2'b00, sr[7:2]};
    end
  end

  // Pixel extraction. With flip, pixels leave from the top of each byte.
  // The plane order within the nibble also differs, matching the bitplane
  // wiring of the original chip.
  always_comb begin
    raw_a = 4'h0;
    raw_b = 4'h0;
    if (H) begin
      raw_b = {sr[23], sr[31], sr[7], sr[15]};
      raw_a = {sr[22], sr[30], sr[6], sr[14]};
    end else begin
      raw_b = {sr[24], sr[16], sr[8], sr[0]};
      raw_a = {sr[25], sr[17], sr[9], sr[1]};
    end
  end

  // Output pair ordering depends on whether the line buffer is writing an
  // even or odd pixel pair.
  always_comb begin
    GAD = raw_a;
    GBD = raw_b;
    if (EVEN) begin
      GAD = raw_b;
      GBD = raw_a;
    end
  end

  assign DOTA = |GAD;
  assign DOTB = |GBD;

endmodule

// File: tb/tb_zmc2_dot_shifter.sv
// Testbench for zmc2_dot_shifter: table of directed vectors applied one
// clock each, plus short hand-written sequences for gapless reloads, reset
// mid-group and combinational EVEN/H changes.

module tb_zmc2_dot_shifter;

  logic        clk;
  logic        reset;
  logic        even;
  logic        load;
  logic        h;
  logic [31:0] cr;
  logic [3:0]  gad;
  logic [3:0]  gbd;
  logic        dota;
  logic        dotb;

  int testCount;
  int failCount;

  zmc2_dot_shifter dut (
    .CLK_12M (clk),
    .RESET   (reset),
    .EVEN    (even),
    .LOAD    (load),
    .H       (h),
    .CR      (cr),
    .GAD     (gad),
    .GBD     (gbd),
    .DOTA    (dota),
    .DOTB    (dotb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        hf;
    logic        ev;
    logic [31:0] word;
    logic [3:0]  expA;
    logic [3:0]  expB;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ld, logic hf, logic ev,
                              logic [31:0] word, logic [3:0] expA,
                              logic [3:0] expB);
    vec_t v;
    v.rst = rst; v.ld = ld; v.hf = hf; v.ev = ev;
    v.word = word; v.expA = expA; v.expB = expB;
    return v;
  endfunction

  // Drive inputs away from the edge, clock once, settle just after the edge
  task automatic applyStimulus(input logic rst, input logic ld,
                               input logic hf, input logic ev,
                               input logic [31:0] word);
    @(negedge clk);
    reset = rst;
    load  = ld;
    h     = hf;
    even  = ev;
    cr    = word;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expA,
                             input logic [3:0] expB);
    logic expDotA;
    logic expDotB;
    expDotA = (expA != 4'h0);
    expDotB = (expB != 4'h0);
    testCount++;
    if (gad !== expA || gbd !== expB || dota !== expDotA || dotb !== expDotB) begin
      failCount++;
      $display("[TB] FAIL %s: got GAD=%h GBD=%h DOTA=%b DOTB=%b, expected GAD=%h GBD=%h DOTA=%b DOTB=%b",
               name, gad, gbd, dota, dotb, expA, expB, expDotA, expDotB);
    end
  endtask

  initial begin
    logic [3:0] streamA[5];
    logic [3:0] streamB[5];

    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    load  = 1'b0;
    h     = 1'b0;
    even  = 1'b0;
    cr    = 32'hFFFF_FFFF;

    //            rst   ld    h     even  cr            A     B
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0, 4'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0, 4'h0));
    // all-ones word: four opaque pairs then transparent
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'hF, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    // single bits, no flip
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 4'h0, 4'h1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h1, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    // single bits, flipped
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 4'h0, 4'h2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 4'h2, 4'h0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 4'h2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    // pair swap
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 4'h1, 4'h0));
    // reload mid-group
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'hF, 4'hF));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'hF));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0002, 4'h1, 4'h0));
    // reset beats load
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0, 4'h0));
    // mixed planes, no flip: A = {0,1,0,1}, B = {0,0,1,1}
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0002_0103, 4'h5, 4'h3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0));
    // mixed planes, flipped: A = {1,0,0,1}, B = {0,1,0,1}
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h8040_C000, 4'h9, 4'h5));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 4'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].hf, vecs[i].ev, vecs[i].word);
      checkOutput($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB);
    end

    // Gapless stream: byte0 = 1110_0100 gives pairs (A,B) = 00,01,10,11,
    // then a reload of 0xFF lands exactly on the fifth edge.
    streamA = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    streamB = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1};
    for (int i = 0; i < 5; i++) begin
      if (i == 0)
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00E4);
      else if (i == 4)
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF);
      else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
      checkOutput($sformatf("stream%0d", i), streamA[i], streamB[i]);
    end

    // Reset in the middle of a group clears the remaining pixels
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    checkOutput("pre_reset_mid", 4'hF, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    checkOutput("reset_mid", 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    checkOutput("after_reset_mid", 4'h0, 4'h0);

    // EVEN and H act combinationally on the held register contents
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001);
    checkOutput("comb_base", 4'h0, 4'h1);
    load = 1'b0;
    even = 1'b1;
    #1;
    checkOutput("comb_even", 4'h1, 4'h0);
    h = 1'b1;
    #1;
    checkOutput("comb_flip", 4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
